// File: rtl/ramb_arbiter.sv
// ramb_arbiter: round-robin arbiter sharing the RAM port-B channel between two requesters
module ramb_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int TIMEOUT = 15
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [7:0]        m0_wdata,
  output logic              m0_ack,
  output logic [7:0]        m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [7:0]        m1_wdata,
  output logic              m1_ack,
  output logic [7:0]        m1_rdata,
  output logic [ADDR_W-1:0] ramb_addr,
  output logic              ramb_wr,
  output logic              ramb_rd,
  output logic [7:0]        ramb_dout,
  input  logic [7:0]        ramb_din,
  input  logic              ramb_wr_ack,
  input  logic              ramb_rd_ack,
  output logic              busy,
  output logic              timeout_o
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t            state_q, state_d;
  logic              last_q, last_d, gnt_q, gnt_d, we_q, we_d;
  logic [7:0]        cnt_q, cnt_d, dout_q, dout_d, rd0_q, rd0_d, rd1_q, rd1_d, data;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              wr_q, wr_d, rd_q, rd_d, ack0_q, ack0_d, ack1_q, ack1_d;
  logic              to_q, to_d, busy_q, busy_d, hit, sel, fin, abort;
  assign hit  = we_q ? ramb_wr_ack : ramb_rd_ack;
  // on a tie the requester that did not win last time gets the grant
  assign sel  = (m0_req && m1_req) ? ~last_q : m1_req;
  assign data = abort ? 8'hFF : ramb_din;
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    we_d    = we_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    dout_d  = dout_q;
    rd0_d   = rd0_q;
    rd1_d   = rd1_q;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    to_d    = 1'b0;
    fin     = 1'b0;
    abort   = 1'b0;
    case (state_q)
      IDLE: if (m0_req || m1_req) begin
        gnt_d   = sel;
        last_d  = sel;
        we_d    = sel ? m1_we : m0_we;
        addr_d  = sel ? m1_addr : m0_addr;
        dout_d  = sel ? m1_wdata : m0_wdata;
        wr_d    = we_d;
        rd_d    = !we_d;
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d   = 8'd0;
        fin     = hit;
        state_d = hit ? DONE : WAIT;
      end
      WAIT: begin
        abort   = !hit && cnt_q == 8'(TIMEOUT - 1);
        fin     = hit || abort;
        cnt_d   = fin ? cnt_q : cnt_q + 8'd1;
        state_d = fin ? DONE : WAIT;
      end
      default: state_d = IDLE;
    endcase
    if (fin) begin
      ack0_d = !gnt_q;
      ack1_d = gnt_q;
      to_d   = abort;
      rd0_d  = (!we_q && !gnt_q) ? data : rd0_q;
      rd1_d  = (!we_q && gnt_q) ? data : rd1_q;
    end
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      cnt_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      rd0_q   <= '0;
      rd1_q   <= '0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      to_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      we_q    <= we_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      dout_q  <= dout_d;
      rd0_q   <= rd0_d;
      rd1_q   <= rd1_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      to_q    <= to_d;
      busy_q  <= busy_d;
    end
  end
  assign ramb_addr = addr_q;
  assign ramb_dout = dout_q;
  assign ramb_wr   = wr_q;
  assign ramb_rd   = rd_q;
  assign m0_ack    = ack0_q;
  assign m1_ack    = ack1_q;
  assign m0_rdata  = rd0_q;
  assign m1_rdata  = rd1_q;
  assign busy      = busy_q;
  assign timeout_o = to_q;
endmodule

// File: tb/tb_ramb_arbiter.sv
// tb_ramb_arbiter: directed checks of grant order, latency, read data, timeout and reset abort
module tb_ramb_arbiter;
  logic        clk_sys = 1'b0, reset = 1'b1;
  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [15:0] m0_addr = 0, m1_addr = 0;
  logic [7:0]  m0_wdata = 0, m1_wdata = 0;
  logic        m0_ack, m1_ack, ramb_wr, ramb_rd, busy, timeout_o;
  logic [7:0]  m0_rdata, m1_rdata, ramb_dout;
  logic [15:0] ramb_addr;
  logic [7:0]  ramb_din = 0;
  logic        ramb_wr_ack = 0, ramb_rd_ack = 0;
  int          vectors = 0, errors = 0, n;
  ramb_arbiter #(.ADDR_W(16), .TIMEOUT(15)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ramb_addr(ramb_addr), .ramb_wr(ramb_wr), .ramb_rd(ramb_rd), .ramb_dout(ramb_dout),
    .ramb_din(ramb_din), .ramb_wr_ack(ramb_wr_ack), .ramb_rd_ack(ramb_rd_ack),
    .busy(busy), .timeout_o(timeout_o)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  initial begin
    step();
    step();
    chk("rst_busy", 16'(busy), 16'd0);
    chk("rst_acks", {14'd0, m0_ack, m1_ack}, 16'd0);
    chk("rst_strb", {14'd0, ramb_wr, ramb_rd}, 16'd0);
    chk("rst_addr", ramb_addr, 16'h0000);
    chk("rst_dout", 16'(ramb_dout), 16'h0000);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 16'h0000);
    chk("rst_to", 16'(timeout_o), 16'd0);
    reset = 0;
    // single write from m0
    m0_req = 1; m0_we = 1; m0_addr = 16'h8123; m0_wdata = 8'h5A;
    step();
    chk("wr_strobe", {14'd0, ramb_wr, ramb_rd}, 16'b10);
    chk("wr_addr", ramb_addr, 16'h8123);
    chk("wr_dout", 16'(ramb_dout), 16'h005A);
    chk("wr_busy", 16'(busy), 16'd1);
    step();
    chk("wr_strobe_off", 16'(ramb_wr), 16'd0);
    chk("wr_ack_early", 16'(m0_ack), 16'd0);
    ramb_wr_ack = 1;
    step();
    chk("wr_m0_ack", {14'd0, m0_ack, m1_ack}, 16'b10);
    ramb_wr_ack = 0; m0_req = 0;
    step();
    chk("wr_ack_pulse", {14'd0, m0_ack, m1_ack}, 16'b00);
    chk("wr_idle", 16'(busy), 16'd0);
    // single read from m1
    m1_req = 1; m1_we = 0; m1_addr = 16'h0400;
    step();
    chk("rd_strobe", {14'd0, ramb_wr, ramb_rd}, 16'b01);
    chk("rd_addr", ramb_addr, 16'h0400);
    step();
    chk("rd_strobe_off", 16'(ramb_rd), 16'd0);
    ramb_rd_ack = 1; ramb_din = 8'hC3;
    step();
    chk("rd_m1_ack", {14'd0, m0_ack, m1_ack}, 16'b01);
    chk("rd_m1_rdata", 16'(m1_rdata), 16'h00C3);
    ramb_rd_ack = 0; ramb_din = 0; m1_req = 0;
    step();
    chk("rd_ack_pulse", 16'(m1_ack), 16'd0);
    // contention from reset: grants alternate starting with m0, 4 cycles each
    reset = 1;
    step();
    reset = 0;
    m0_req = 1; m0_we = 0; m0_addr = 16'h1111;
    m1_req = 1; m1_we = 0; m1_addr = 16'h2222;
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr%0d_addr", i), ramb_addr, (i % 2) ? 16'h2222 : 16'h1111);
      chk($sformatf("rr%0d_rd", i), 16'(ramb_rd), 16'd1);
      step();
      ramb_rd_ack = 1; ramb_din = 8'(8'h40 + i);
      step();
      chk($sformatf("rr%0d_acks", i), {14'd0, m0_ack, m1_ack}, (i % 2) ? 16'b01 : 16'b10);
      chk($sformatf("rr%0d_rdata", i), 16'((i % 2) ? m1_rdata : m0_rdata), 16'(8'h40 + i));
      ramb_rd_ack = 0;
      if (i == 7) begin m0_req = 0; m1_req = 0; end
      step();
      chk($sformatf("rr%0d_idle", i), 16'(busy), 16'd0);
    end
    step();
    chk("rr_stop", {14'd0, busy, ramb_rd}, 16'd0);
    // timeout: read never acknowledged
    m0_req = 1; m0_we = 0; m0_addr = 16'h0042;
    step();
    chk("to_strobe", 16'(ramb_rd), 16'd1);
    n = 0;
    while (!m0_ack && n < 40) begin
      step();
      n++;
      if (!m0_ack) chk("to_early", 16'(timeout_o), 16'd0);
    end
    chk("to_latency", 16'(n), 16'd16);
    chk("to_m0_ack", 16'(m0_ack), 16'd1);
    chk("to_rdata", 16'(m0_rdata), 16'h00FF);
    chk("to_pulse", 16'(timeout_o), 16'd1);
    m0_req = 0;
    step();
    chk("to_idle", {14'd0, busy, timeout_o}, 16'd0);
    // non-matching ack ignored, then normal completion
    m0_req = 1; m0_we = 1; m0_addr = 16'h0010; m0_wdata = 8'h77;
    step();
    step();
    ramb_rd_ack = 1;
    step();
    chk("wa_ignored", {13'd0, busy, m0_ack, ramb_wr}, 16'b100);
    ramb_rd_ack = 0; ramb_wr_ack = 1;
    step();
    chk("wa_done", 16'(m0_ack), 16'd1);
    ramb_wr_ack = 0; m0_req = 0;
    step();
    // reset in WAIT, late ack ignored
    m0_req = 1; m0_addr = 16'h0020;
    step();
    step();
    step();
    chk("rw_waiting", 16'(busy), 16'd1);
    reset = 1; m0_req = 0;
    step();
    chk("rw_reset", {13'd0, busy, m0_ack, ramb_wr}, 16'd0);
    chk("rw_addr", ramb_addr, 16'h0000);
    reset = 0; ramb_wr_ack = 1;
    step();
    chk("rw_late_ack", {14'd0, busy, m0_ack}, 16'd0);
    ramb_wr_ack = 0;
    step();
    chk("rw_still_idle", {14'd0, busy, m0_ack}, 16'd0);
    // requester drops req after ISSUE
    m1_req = 1; m1_we = 0; m1_addr = 16'h0300;
    step();
    step();
    m1_req = 0; ramb_rd_ack = 1; ramb_din = 8'h5E;
    step();
    chk("rq_ack", 16'(m1_ack), 16'd1);
    chk("rq_rdata", 16'(m1_rdata), 16'h005E);
    ramb_rd_ack = 0;
    step();
    chk("rq_idle", 16'(busy), 16'd0);
    step();
    chk("rq_no_reissue", {14'd0, busy, ramb_rd}, 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
